// File: rtl/apb_pkg.sv
// Shared types, response encoding and sizing helpers for the wait-state APB master.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    // Response status packed as {err, timeout}
    localparam int unsigned RSP_STAT_W  = 2;
    localparam logic [1:0]  RSP_OK      = 2'b00;
    localparam logic [1:0]  RSP_SLVERR  = 2'b10;
    localparam logic [1:0]  RSP_TIMEOUT = 2'b11;

    function automatic int unsigned wait_cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait counter; expired is registered and flags that the current
// wait cycle is the last one allowed before the transfer is aborted.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic cnt_en,
    output logic expired
);

    localparam int unsigned CNT_W      = wait_cnt_width(TIMEOUT);
    localparam int unsigned LAST       = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit          TIMEOUT_EN = (TIMEOUT != 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expired_q, expired_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // Look ahead so expired lines up with the cycle the counter holds LAST
        expired_d = TIMEOUT_EN && (cnt_d == CNT_W'(LAST));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/apb_master_ws.sv
// APB master with slave wait states, slave error and access timeout; accepts
// one command at a time and returns a one-cycle response pulse.
module apb_master_ws
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              Presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              Psel,
    output logic              Penable,
    output logic              Pwrite,
    output logic [ADDR_W-1:0] Paddress,
    output logic [DATA_W-1:0] PWdata,
    input  logic              Pready,
    input  logic [DATA_W-1:0] PRdata,
    input  logic              Pslverr
);

    apb_state_e            state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]     paddr_q, paddr_d;
    logic [DATA_W-1:0]     pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic [RSP_STAT_W-1:0] rsp_stat_q, rsp_stat_d;
    logic                  tmr_clear, tmr_en, tmr_expired;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (PCLK),
        .rst_n   (Presetn),
        .clear   (tmr_clear),
        .cnt_en  (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_stat_d  = rsp_stat_q;
        tmr_clear   = 1'b0;
        tmr_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_wdata;
                    psel_d    = 1'b1;
                    tmr_clear = 1'b1;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                tmr_en = !Pready;
                // Pready takes priority over a timeout firing in the same cycle
                if (Pready) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_stat_d  = Pslverr ? RSP_SLVERR : RSP_OK;
                    rsp_rdata_d = pwrite_q ? '0 : PRdata;
                    state_d     = ST_IDLE;
                end else if (tmr_expired) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_stat_d  = RSP_TIMEOUT;
                    rsp_rdata_d = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge PCLK or negedge Presetn) begin
        if (!Presetn) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_stat_q  <= RSP_OK;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_stat_q  <= rsp_stat_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign Psel        = psel_q;
    assign Penable     = penable_q;
    assign Pwrite      = pwrite_q;
    assign Paddress    = paddr_q;
    assign PWdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_stat_q[1];
    assign rsp_timeout = rsp_stat_q[0];

endmodule
